// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> RESP handshake to a word-wide memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] tmo_cnt;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic       illegal;
  logic       early_err;
  logic [1:0] eff_off;
  logic [3:0] be;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == ACCESS);

  // Request decode: lane offset after natural alignment, byte enables, legality.
  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
    case (req_funct3[1:0])
      2'b00: begin
        eff_off = req_addr[1:0];
        be      = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        eff_off = {req_addr[1], 1'b0};
        be      = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        eff_off = 2'b00;
        be      = 4'b1111;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    early_err = illegal || (eff_off != req_addr[1:0]);
`else
    early_err = illegal;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (early_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state     <= ACCESS;
              tmo_cnt   <= 8'd0;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= req_wdata << {eff_off, 3'b000};
              f3_q      <= req_funct3;
              off_q     <= eff_off;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= mem_we ? 32'd0 : load_extend(f3_q, off_q, mem_rdata);
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random transactions
// against an arithmetic reference model, and a reset-during-access sequence.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackdly;
    logic        err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          ncyc;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expected outcome from size, alignment and ack delay.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int ackdly);
    vec_t v;
    longint unsigned sz, ea, off, rv;
    longint val;
    bit illegal, mis, trap;
    v = '{we, f3, addr, wdata, rdata, ackdly, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 0, 0};
    sz = 64'd1 << (f3 % 4);
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
    mis = !illegal && (addr % sz != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    if (illegal || (trap && mis)) begin
      v.err = 1'b1; v.ncyc = 0; v.lat = 1;
      return v;
    end
    ea  = addr - addr % sz;
    off = ea % 4;
    v.exp_addr  = 32'(ea - off);
    v.exp_be    = 4'(((64'd1 << sz) - 1) << off);
    v.exp_wdata = 32'({32'd0, wdata} << (8 * off));
    if (ackdly >= TO) begin
      v.err = 1'b1; v.ncyc = TO; v.lat = TO + 1;
      return v;
    end
    v.ncyc = ackdly + 1;
    v.lat  = ackdly + 2;
    if (!we) begin
      rv = longint'(rdata) >> (8 * off);
      if (sz < 4) rv = rv % (64'd1 << (8 * sz));
      val = longint'(rv);
      if (f3 < 4 && sz < 4 && rv >= (64'd1 << (8 * sz - 1))) val = val - longint'(64'd1 << (8 * sz));
      v.exp_rdata = 32'(val);
    end
    return v;
  endfunction

  // Drives one request starting at a negedge; acts as the memory; returns at a negedge.
  task automatic run_txn(input vec_t v, input string tag);
    int ncyc, lat, waitc;
    logic [31:0] a0, w0, r_rd;
    logic [3:0]  b0;
    logic        we0, r_err;
    bit          done, unstable;
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    ncyc = 0; lat = 0; done = 0; unstable = 0;
    a0 = 0; w0 = 0; b0 = 0; we0 = 0; r_rd = 0; r_err = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        done = 1; mem_ack = 1'b0; r_err = rsp_err; r_rd = rsp_rdata;
      end else if (mem_req) begin
        ncyc++;
        if (ncyc == 1) begin
          a0 = mem_addr; b0 = mem_be; w0 = mem_wdata; we0 = mem_we;
        end else if (a0 !== mem_addr || b0 !== mem_be || w0 !== mem_wdata || we0 !== mem_we) begin
          unstable = 1;
        end
        if (ncyc - 1 == v.ackdly) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
    chk({tag, " rsp_seen"}, {31'd0, done}, 32'd1);
    chk({tag, " rsp_err"}, {31'd0, r_err}, {31'd0, v.err});
    chk({tag, " rsp_rdata"}, r_rd, v.exp_rdata);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " req_cycles"}, 32'(ncyc), 32'(v.ncyc));
    if (v.ncyc > 0 && ncyc > 0) begin
      chk({tag, " mem_addr"}, a0, v.exp_addr);
      chk({tag, " mem_be"}, {28'd0, b0}, {28'd0, v.exp_be});
      chk({tag, " mem_wdata"}, w0, v.exp_wdata);
      chk({tag, " mem_we"}, {31'd0, we0}, {31'd0, v.we});
      chk({tag, " stable"}, {31'd0, unstable}, 32'd0);
    end
    @(negedge clk);
    chk({tag, " rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " b2b_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    int unsigned sz;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    tbl.push_back('{1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'd0, 1, 2});
    tbl.push_back('{1'b0, 3'b000, 32'h103, 32'd0, 32'h80112233, 1, 1'b0, 32'hFFFFFF80, 32'h100, 4'b1000, 32'd0, 2, 3});
    tbl.push_back('{1'b0, 3'b100, 32'h103, 32'd0, 32'h80112233, 0, 1'b0, 32'h00000080, 32'h100, 4'b1000, 32'd0, 1, 2});
    tbl.push_back('{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h12345678, 0, 1'b0, 32'd0, 32'h200, 4'b1100, 32'hABCD0000, 1, 2});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1'b0, 3'b010, 32'h101, 32'd0, 32'hCAFEF00D, 0, 1'b1, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1});
`else
    tbl.push_back('{1'b0, 3'b010, 32'h101, 32'd0, 32'hCAFEF00D, 0, 1'b0, 32'hCAFEF00D, 32'h100, 4'b1111, 32'd0, 1, 2});
`endif
    tbl.push_back('{1'b0, 3'b010, 32'h400, 32'd0, 32'h11111111, 9, 1'b1, 32'd0, 32'h400, 4'b1111, 32'd0, 4, 5});
    tbl.push_back('{1'b0, 3'b011, 32'h500, 32'd0, 32'h22222222, 0, 1'b1, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1});
    tbl.push_back('{1'b1, 3'b100, 32'h501, 32'h55, 32'h0, 0, 1'b1, 32'd0, 32'd0, 4'd0, 32'd0, 0, 1});
    tbl.push_back('{1'b0, 3'b001, 32'h306, 32'd0, 32'h80017FFF, 3, 1'b0, 32'hFFFF8001, 32'h304, 4'b1100, 32'd0, 4, 5});
    tbl.push_back('{1'b0, 3'b101, 32'h306, 32'd0, 32'h80017FFF, 1, 1'b0, 32'h00008001, 32'h304, 4'b1100, 32'd0, 2, 3});
    tbl.push_back('{1'b1, 3'b010, 32'h40C, 32'h11223344, 32'h0, 2, 1'b0, 32'd0, 32'h40C, 4'b1111, 32'h11223344, 3, 4});

    #3;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_be", {28'd0, mem_be}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom;
      sz   = 1 << (f3 % 4);
      if (we && sz <= 4) addr = addr - addr % sz;
      v = model(we, f3, addr, $urandom, $urandom, int'($urandom_range(0, 5)));
      run_txn(v, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of an access, then a stale ack after release.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid in_access", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid mem_addr", mem_addr, 32'd0);
    chk("rstmid mem_be", {28'd0, mem_be}, 32'd0);
    chk("rstmid mem_wdata", mem_wdata, 32'd0);
    chk("rstmid mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stale_ack rsp_valid%0d", c), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("stale_ack mem_req%0d", c), {31'd0, mem_req}, 32'd0);
      chk($sformatf("stale_ack ready%0d", c), {31'd0, req_ready}, 32'd1);
    end
    mem_ack = 1'b0;
    run_txn(tbl[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
